mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between `ex_stage` and writeback. It takes the registered EX bus and performs loads and stores through a req/gnt/rvalid data-memory port, aligning and extending load data into the bus. It stalls upstream while an access is in flight and registers the result bus for writeback. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- `XLEN`, 32, data/address width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `bus_i` input `core::pipeline_bus_t`: registered EX output. Uses `mem_op`, `alu_result` (address), `rs2_data` (store data) and `wb_data`.
- `mem_bus_o` output `core::pipeline_bus_t`: registered bus to writeback.
- `stall_o` output 1: upstream must hold `bus_i` stable while high.
- `misalign_o` output 1: registered; valid with `mem_bus_o`.
- `dmem_req_o` output 1: memory request.
- `dmem_we_o` output 1: 1 = store.
- `dmem_addr_o` output XLEN: word-aligned address, `{alu_result[XLEN-1:2],2'b00}`.
- `dmem_be_o` output 4: byte enables.
- `dmem_wdata_o` output XLEN: lane-positioned store data.
- `dmem_gnt_i` input 1: request accepted this cycle.
- `dmem_rvalid_i` input 1: load data valid this cycle.
- `dmem_rdata_i` input XLEN: load data, full word.

## Operation
- FSM states and transitions:
  - IDLE: a legal memory op asserts `dmem_req_o` combinationally.
    - Store with gnt: access completes; stay in IDLE.
    - Load with gnt: go to WAIT.
    - No gnt: go to REQ.
  - REQ: hold `dmem_req_o`, address, be and wdata until gnt, then act as in IDLE.
  - WAIT: `dmem_req_o`=0. On rvalid, capture data and return to IDLE.
- `stall_o` = (IDLE or REQ, legal mem op, not (store and gnt)) or (WAIT and not rvalid). It deasserts in the completing cycle so upstream advances on that edge.
- While `stall_o` is high, `mem_bus_o` is loaded with a bubble. The bubble has `mem_op`=MEM_NOP, `alu_op`=ALU_NOP, `format`=NOP and `instr`=`riscv::I_NOP`.
- Misalignment:
  - Cases: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0.
  - No request is issued and no stall occurs.
  - Next edge: `mem_bus_o` is a bubble and `misalign_o`=1 for one cycle.
- Store lanes:
  - SB: be = `4'b0001<<addr[1:0]`, byte replicated ×4.
  - SH: be = `addr[1]`?`1100`:`0011`, half replicated ×2.
  - SW: be = `1111`.
- Loads:
  - Select the lane by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is taken as-is.
  - The result replaces `wb_data`.
- Non-memory op: `mem_bus_o <= bus_i` next edge. `dmem_req_o`=0.
- `rvalid` outside WAIT is ignored.

## Timing
- Reset (`rst`=0 at an edge):
  - State → IDLE; `misalign_o`=0.
  - `mem_bus_o` = bubble with all other bits 0.
  - `dmem_req_o`, `dmem_we_o` and `stall_o` are forced 0 combinationally while `rst`=0.
  - Reset mid-access abandons it; a late rvalid is dropped.
- Latency:
  - Non-memory op: 1 cycle.
  - Store with gnt in cycle 0: 1 cycle, no stall.
  - Load with gnt in cycle 0 and rvalid in cycle 1: result registered at end of cycle 1, one stall cycle.
- Each extra cycle without gnt or rvalid adds exactly one stall cycle and one bubble.
- rvalid never arrives in the same cycle as gnt; the earliest is gnt+1.
- At most one outstanding access.

## Structure
- `core` package holds:
  - `mem_op_t`: MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
  - `pipeline_bus_t` fields `alu_result`, `rs2_data` and `wb_data`.
  - A `mem_state_t` enum.
- Sub-module `lsu_align`, combinational: store be/wdata formatting, load extract/extend, misalign detect.
- `mem_stage` holds the FSM and output register.

## Test plan
- ADD with `wb_data`=0x1234 → `mem_bus_o.wb_data`=0x1234 one cycle later; `dmem_req_o` never 1.
- SB addr 0x1003, data 0xAB, gnt immediate → be=`1000`, wdata=0xABABABAB, addr=0x1000, `stall_o`=0.
- LB addr 0x2001, gnt 2 cycles late, rdata=0x0000_8000 arriving 3 cycles after gnt → stall_o high 5 cycles, 5 bubbles, then `wb_data`=0xFFFF_FF80.
- LHU addr 0x2002, rdata=0xF00D_0000 → `wb_data`=0x0000_F00D. LH on the same data → 0xFFFF_F00D.
- SW addr 0x3002 → no req, no stall, next cycle `misalign_o`=1 and `mem_bus_o` a bubble.
- Reset in WAIT, then rvalid → state IDLE, no writeback of data, `stall_o`=0.

Source files
------------

// File: rtl/core_pkg.sv
// riscv and core packages: shared instruction constants, pipeline bus and memory-op types.
`default_nettype none

package riscv;
  localparam logic [31:0] I_NOP = 32'h0000_0013;  // addi x0, x0, 0
endpackage

package core;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [2:0] {
    NOP, R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } format_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    format_t         format;
    alu_op_t         alu_op;
    mem_op_t         mem_op;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] wb_data;
  } pipeline_bus_t;

  function automatic pipeline_bus_t bubble();
    pipeline_bus_t b;
    b        = '0;
    b.instr  = riscv::I_NOP;
    b.format = NOP;
    b.alu_op = ALU_NOP;
    b.mem_op = MEM_NOP;
    return b;
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_mem(mem_op_t op);
    return is_store(op) || (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction
endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational store lane formatting, load extraction/extension and misalign detect.
`default_nettype none

module lsu_align
  import core::*;
(
  input  mem_op_t     mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata     = store_data;
    load_data = rdata;
    misalign  = 1'b0;
    case (mem_op)
      MEM_LB:  load_data = {{24{lane_b[7]}}, lane_b};
      MEM_LBU: load_data = {24'h0, lane_b};
      MEM_LH: begin
        misalign  = addr_lo[0];
        load_data = {{16{lane_h[15]}}, lane_h};
      end
      MEM_LHU: begin
        misalign  = addr_lo[0];
        load_data = {16'h0, lane_h};
      end
      MEM_LW:  misalign = |addr_lo;
      MEM_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MEM_SH: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
      end
      MEM_SW: begin
        misalign = |addr_lo;
        be       = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: load/store access FSM over a req/gnt/rvalid port with a registered writeback bus.
`default_nettype none

module mem_stage
  import core::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  pipeline_bus_t   bus_i,
  output pipeline_bus_t   mem_bus_o,
  output logic            stall_o,
  output logic            misalign_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  mem_state_t  state;
  logic        mis;
  logic        mem_op;
  logic        legal;
  logic        store;
  logic        req_phase;
  logic [31:0] load_data;

  lsu_align u_align (
    .mem_op     (bus_i.mem_op),
    .addr_lo    (bus_i.alu_result[1:0]),
    .store_data (bus_i.rs2_data),
    .rdata      (dmem_rdata_i),
    .be         (dmem_be_o),
    .wdata      (dmem_wdata_o),
    .load_data  (load_data),
    .misalign   (mis)
  );

  assign mem_op    = is_mem(bus_i.mem_op);
  assign store     = is_store(bus_i.mem_op);
  assign legal     = mem_op && !mis;
  assign req_phase = (state == IDLE) || (state == REQ);

  // Upstream holds bus_i stable while stalled, so address/data need no local copy.
  assign dmem_addr_o = {bus_i.alu_result[XLEN-1:2], 2'b00};
  assign dmem_req_o  = rst && req_phase && legal;
  assign dmem_we_o   = dmem_req_o && store;
  assign stall_o     = rst && ((req_phase && legal && !(store && dmem_gnt_i)) ||
                               ((state == WAIT) && !dmem_rvalid_i));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_bus_o  <= bubble();
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        IDLE, REQ: begin
          if (legal) begin
            mem_bus_o <= bubble();
            if (!dmem_gnt_i) begin
              state <= REQ;
            end else if (store) begin
              mem_bus_o <= bus_i;
              state     <= IDLE;
            end else begin
              state <= WAIT;
            end
          end else if (mem_op) begin
            mem_bus_o  <= bubble();
            misalign_o <= 1'b1;
            state      <= IDLE;
          end else begin
            mem_bus_o <= bus_i;
            state     <= IDLE;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            mem_bus_o         <= bus_i;
            mem_bus_o.wb_data <= load_data;
            state             <= IDLE;
          end else begin
            mem_bus_o <= bubble();
          end
        end
        default: begin
          mem_bus_o <= bubble();
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with scripted gnt/rvalid latencies.
`default_nettype none

module tb_mem_stage;
  import core::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  pipeline_bus_t bus_i;
  pipeline_bus_t mem_bus_o;
  logic          stall_o, misalign_o, dmem_req_o, dmem_we_o;
  logic [31:0]   dmem_addr_o, dmem_wdata_o;
  logic [3:0]    dmem_be_o;
  logic          dmem_gnt_i = 1'b0;
  logic          dmem_rvalid_i = 1'b0;
  logic [31:0]   dmem_rdata_i = 32'h0;

  typedef struct packed {
    logic        mis;
    logic [31:0] wb;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_i         (bus_i),
    .mem_bus_o     (mem_bus_o),
    .stall_o       (stall_o),
    .misalign_o    (misalign_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pipeline_bus_t tb_bubble();
    pipeline_bus_t b;
    b        = '0;
    b.instr  = 32'h0000_0013;
    b.format = NOP;
    b.alu_op = ALU_NOP;
    b.mem_op = MEM_NOP;
    return b;
  endfunction

  function automatic logic is_bub(pipeline_bus_t b);
    return (b.mem_op == MEM_NOP) && (b.alu_op == ALU_NOP) && (b.format == NOP) &&
           (b.instr == 32'h0000_0013);
  endfunction

  function automatic pipeline_bus_t mk(mem_op_t op, logic [31:0] addr, logic [31:0] rs2,
                                       logic [31:0] wb);
    pipeline_bus_t b;
    b            = '0;
    b.instr      = 32'h0052_8033;
    b.format     = R_TYPE;
    b.alu_op     = ALU_ADD;
    b.mem_op     = op;
    b.rd         = 5'd5;
    b.rd_we      = 1'b1;
    b.alu_result = addr;
    b.rs2_data   = rs2;
    b.wb_data    = wb;
    return b;
  endfunction

  function automatic logic tb_misaligned(mem_op_t op, logic [31:0] addr);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return addr[0];
      MEM_LW, MEM_SW:          return addr[1:0] != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

  // Every non-bubble output (or misalign pulse) must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst && (!is_bub(mem_bus_o) || misalign_o)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("misalign", {31'h0, misalign_o}, {31'h0, mon_e.mis});
        check_eq("wb_data", mem_bus_o.wb_data, mon_e.wb);
        if (mon_e.mis) check_eq("mis_bubble", {31'h0, is_bub(mem_bus_o)}, 32'd1);
      end
    end
  end

  task automatic run_op(input pipeline_bus_t b, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input int exp_stalls,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    logic legal, store, done, prev_stall;
    int   stalls, bubbles;
    store      = (b.mem_op == MEM_SB) || (b.mem_op == MEM_SH) || (b.mem_op == MEM_SW);
    legal      = (b.mem_op != MEM_NOP) && !tb_misaligned(b.mem_op, b.alu_result);
    bus_i      = b;
    dmem_rdata_i = rdata;
    done       = 1'b0;
    prev_stall = 1'b0;
    stalls     = 0;
    bubbles    = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dmem_gnt_i    = legal && (cyc == gnt_dly);
      dmem_rvalid_i = legal && !store && (cyc == gnt_dly + rv_dly);
      @(negedge clk);
      if (prev_stall && is_bub(mem_bus_o)) bubbles++;
      if (!legal) check_eq("no_req", {31'h0, dmem_req_o}, 32'd0);
      if (dmem_req_o && dmem_gnt_i) begin
        check_eq("addr", dmem_addr_o, {b.alu_result[31:2], 2'b00});
        check_eq("we", {31'h0, dmem_we_o}, {31'h0, store});
        if (store) begin
          check_eq("be", {28'h0, dmem_be_o}, {28'h0, exp_be});
          check_eq("wdata", dmem_wdata_o, exp_wdata);
        end
      end
      if (stall_o) stalls++;
      prev_stall = stall_o;
      done       = !stall_o;
      @(posedge clk);
      #1;
    end
    check_eq("done", {31'h0, done}, 32'd1);
    check_eq("stalls", stalls, exp_stalls);
    check_eq("bubbles", bubbles, exp_stalls);
    bus_i         = tb_bubble();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // A legal load is presented during reset: request and stall must stay low.
    bus_i = mk(MEM_LW, 32'h0000_2000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", {31'h0, dmem_req_o}, 32'd0);
    check_eq("rst_we", {31'h0, dmem_we_o}, 32'd0);
    check_eq("rst_stall", {31'h0, stall_o}, 32'd0);
    check_eq("rst_wb", mem_bus_o.wb_data, 32'h0);
    check_eq("rst_bubble", {31'h0, is_bub(mem_bus_o)}, 32'd1);
    check_eq("rst_mis", {31'h0, misalign_o}, 32'd0);
    bus_i = tb_bubble();
    @(posedge clk);
    #1;
    rst = 1'b1;

    sb_q.push_back('{1'b0, 32'h0000_1234});
    run_op(mk(MEM_NOP, 32'h0, 32'h0, 32'h0000_1234), 0, 0, 32'h0, 0, 4'h0, 32'h0);

    sb_q.push_back('{1'b0, 32'h0000_0055});
    run_op(mk(MEM_SB, 32'h0000_1003, 32'h0000_00AB, 32'h55), 0, 0, 32'h0, 0, 4'b1000, 32'hABAB_ABAB);

    sb_q.push_back('{1'b0, 32'h0000_0066});
    run_op(mk(MEM_SH, 32'h0000_1002, 32'h1234_BEEF, 32'h66), 1, 0, 32'h0, 1, 4'b1100, 32'hBEEF_BEEF);

    sb_q.push_back('{1'b0, 32'h0000_0077});
    run_op(mk(MEM_SW, 32'h0000_1004, 32'hCAFE_F00D, 32'h77), 0, 0, 32'h0, 0, 4'b1111, 32'hCAFE_F00D);

    sb_q.push_back('{1'b0, 32'hFFFF_FF80});
    run_op(mk(MEM_LB, 32'h0000_2001, 32'h0, 32'h99), 2, 3, 32'h0000_8000, 5, 4'h0, 32'h0);

    sb_q.push_back('{1'b0, 32'h0000_F00D});
    run_op(mk(MEM_LHU, 32'h0000_2002, 32'h0, 32'h99), 0, 1, 32'hF00D_0000, 1, 4'h0, 32'h0);

    sb_q.push_back('{1'b0, 32'hFFFF_F00D});
    run_op(mk(MEM_LH, 32'h0000_2002, 32'h0, 32'h99), 0, 1, 32'hF00D_0000, 1, 4'h0, 32'h0);

    sb_q.push_back('{1'b0, 32'h0000_0080});
    run_op(mk(MEM_LBU, 32'h0000_2003, 32'h0, 32'h99), 0, 1, 32'h8012_3456, 1, 4'h0, 32'h0);

    sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
    run_op(mk(MEM_LW, 32'h0000_2000, 32'h0, 32'h99), 1, 2, 32'hDEAD_BEEF, 3, 4'h0, 32'h0);

    sb_q.push_back('{1'b1, 32'h0});
    run_op(mk(MEM_SW, 32'h0000_3002, 32'h1111_2222, 32'h88), 0, 0, 32'h0, 0, 4'h0, 32'h0);

    sb_q.push_back('{1'b1, 32'h0});
    run_op(mk(MEM_LH, 32'h0000_2001, 32'h0, 32'h88), 0, 0, 32'h0, 0, 4'h0, 32'h0);

    // Reset while waiting for load data; the late rvalid must be dropped.
    bus_i      = mk(MEM_LW, 32'h0000_2000, 32'h0, 32'h0);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    check_eq("rw_req", {31'h0, dmem_req_o}, 32'd1);
    check_eq("rw_stall", {31'h0, stall_o}, 32'd1);
    @(posedge clk);
    #1;
    dmem_gnt_i = 1'b0;
    rst        = 1'b0;
    bus_i      = tb_bubble();
    @(negedge clk);
    check_eq("rw_rst_stall", {31'h0, stall_o}, 32'd0);
    check_eq("rw_rst_req", {31'h0, dmem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    @(negedge clk);
    check_eq("rw_late_stall", {31'h0, stall_o}, 32'd0);
    check_eq("rw_wb0", mem_bus_o.wb_data, 32'h0);
    @(posedge clk);
    #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    check_eq("rw_wb1", mem_bus_o.wb_data, 32'h0);
    check_eq("rw_bubble", {31'h0, is_bub(mem_bus_o)}, 32'd1);
    check_eq("rw_stall_after", {31'h0, stall_o}, 32'd0);

    repeat (3) @(negedge clk);
    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
